cam_pattern_gen: RTL and testbench
==================================

Name: cam_pattern_gen

Overview:
- Camera-sensor emulator for bring-up and regression of the camera capture path without a physical sensor.
- Drives an OV7670-style 8-bit parallel bus (data, VSYNC, HREF) in the PCLK domain; outputs connect directly to the capture block's sensor inputs.
- Emits RGB565 frames with selectable test patterns, high byte first.
- Frame timing is parameterised so benches can run reduced frame sizes.

Parameters:
- H_ACTIVE, 320: active pixels per line. Must be a multiple of 8, ≥8.
- H_BLANK, 144: PCLK cycles with HREF low at the end of each line.
- V_ACTIVE, 240: active lines per frame.
- VS_LINES, 3: line periods with VSYNC high.
- VBP_LINES, 17: line periods of back porch after VSYNC.
- VFP_LINES, 10: line periods of front porch after the active lines.

Ports:
- PCLK  in  1  pixel/byte clock.
- HRESETn  in  1  reset.
- enable  in  1  run request.
- pattern_sel  in  2  0 = colour bars, 1 = ramp, 2 = solid, 3 = checker.
- solid_rgb  in  16  RGB565 value for pattern 2.
- cam_data  out  8  sensor byte.
- cam_vsync  out  1  frame sync, active high.
- cam_href  out  1  line valid.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_cnt  out  8  completed-frame count, wraps.

Behaviour:
- Reset HRESETn, asynchronous, active-low; clock PCLK.
- All outputs are registered.
- Reset values: cam_data = 0, cam_vsync = 0, cam_href = 0, frame_done = 0, frame_cnt = 0, state = IDLE.
- LINE_LEN = 2*H_ACTIVE + H_BLANK cycles.
- Internal counters: col_cnt (byte column 0..LINE_LEN-1) and line_cnt. Each is 12 bits wide and resets to 0 on every state change.
- FSM states:
  - IDLE: all outputs low. If enable is sampled high at edge N, go to VSYNC; cam_vsync = 1 from edge N.
  - VSYNC: cam_vsync = 1 for VS_LINES*LINE_LEN cycles, then go to VBP.
  - VBP: VSYNC and HREF low for VBP_LINES*LINE_LEN cycles, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. Each line has cam_href = 1 for exactly 2*H_ACTIVE cycles starting at col_cnt = 0, then cam_href = 0 for H_BLANK cycles. After the last line, go to VFP.
  - VFP: all low for VFP_LINES*LINE_LEN cycles. On the last cycle, assert frame_done for 1 cycle and increment frame_cnt (255 → 0). Then go to VSYNC if enable = 1, else IDLE.
- Frame period = (VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES) * LINE_LEN cycles. There are no gaps between back-to-back frames.
- enable is sampled only in IDLE and on the last VFP cycle. Deasserting it mid-frame completes the current frame.
- pattern_sel and solid_rgb are latched on entry to VSYNC. Changes during a frame take effect on the next frame.
- Pixel coordinates: x = col_cnt/2 (0..H_ACTIVE-1), y = active line index.
  - Byte phase 0 (even col_cnt): cam_data = pixel[15:8].
  - Byte phase 1 (odd col_cnt): cam_data = pixel[7:0].
  - cam_data = 0 whenever cam_href = 0.
- Patterns:
  - 0, colour bars: 8 bars, each H_ACTIVE/8 pixels wide. Values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a compare counter (no divider) and restarts each line.
  - 1, ramp: R = x[7:3], G = y[7:2], B = 0.
  - 2, solid: latched solid_rgb.
  - 3, checker: FFFF if (x[3] ^ y[3] ^ frame_cnt[0]), else 0000.
- Asynchronous reset mid-frame: outputs drop to their reset values immediately. The next frame starts from VSYNC once enable is seen in IDLE.

Test Plan:
- Reset and idle: assert HRESETn low mid-ACTIVE → cam_href, cam_vsync, cam_data all 0 immediately. After release with enable = 0, outputs stay 0 for 1000 cycles.
- Frame timing, with H_ACTIVE = 8, H_BLANK = 4, V_ACTIVE = 2, VS = VBP = VFP = 1, enable = 1:
  - LINE_LEN = 20 and frame period = 100 cycles.
  - cam_vsync high for 20 cycles.
  - cam_href high for 16 cycles on each of 2 lines, then low for 4.
  - frame_done pulses every 100 cycles.
- Colour bars with the same parameters: byte stream per line = FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00. Both lines are identical.
- Mid-frame changes:
  - Change pattern_sel from 0 to 2 (solid_rgb = 1234) during ACTIVE → current frame stays bars; next frame is 12 34 repeated.
  - Drop enable during VBP → frame completes, frame_done pulses, FSM returns to IDLE, no further VSYNC.
- Checker and counter: run 257 frames → checker phase inverts each frame (pixel 0 of line 0 alternates 0000/FFFF). frame_cnt reads 0 after frame 256 and 1 after frame 257.

Source files
------------

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: OV7670-style sensor emulator producing RGB565 test-pattern frames
// on an 8-bit parallel bus, high byte first.
module cam_pattern_gen #(
    parameter int H_ACTIVE  = 320,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 240,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic        PCLK,
    input  logic        HRESETn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic [7:0]  cam_data,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);
    localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
    localparam int BAR_W    = H_ACTIVE/8;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_col, r_line, w_col_nxt, w_line_nxt, w_lines;
    logic [11:0] r_bpx, w_bpx_nxt;
    logic [2:0]  r_bar, w_bar_nxt;
    logic [1:0]  r_pat;
    logic [15:0] r_solid, w_pix;
    logic        w_eol, w_end, w_last_nxt, w_href_nxt;

    always_comb begin
        w_lines = (r_state == VSYNC)  ? 12'(VS_LINES)  :
                  (r_state == VBP)    ? 12'(VBP_LINES) :
                  (r_state == ACTIVE) ? 12'(V_ACTIVE)  : 12'(VFP_LINES);
        w_eol = r_col == 12'(LINE_LEN-1);
        w_end = w_eol && (r_line == w_lines - 12'd1);
        case (r_state)
            IDLE:    w_state_nxt = enable ? VSYNC : IDLE;
            VSYNC:   w_state_nxt = w_end ? VBP : VSYNC;
            VBP:     w_state_nxt = w_end ? ACTIVE : VBP;
            ACTIVE:  w_state_nxt = w_end ? VFP : ACTIVE;
            default: w_state_nxt = w_end ? (enable ? VSYNC : IDLE) : VFP;
        endcase
        // Counters restart on every state change, including VFP -> VSYNC.
        w_col_nxt  = (w_state_nxt == r_state && r_state != IDLE) ? (w_eol ? 12'd0 : r_col + 12'd1) : 12'd0;
        w_line_nxt = (w_state_nxt == r_state && r_state != IDLE) ? (w_eol ? r_line + 12'd1 : r_line) : 12'd0;
        w_last_nxt = (w_state_nxt == VFP) && (w_line_nxt == 12'(VFP_LINES-1)) && (w_col_nxt == 12'(LINE_LEN-1));
        w_href_nxt = (w_state_nxt == ACTIVE) && (w_col_nxt < 12'(2*H_ACTIVE));
        // Bar index advances on each new pixel once the current bar is full.
        w_bar_nxt = r_bar;
        w_bpx_nxt = r_bpx;
        if (w_col_nxt == 12'd0) begin
            w_bar_nxt = 3'd0;
            w_bpx_nxt = 12'd0;
        end else if (!w_col_nxt[0]) begin
            w_bar_nxt = (r_bpx == 12'(BAR_W-1)) ? r_bar + 3'd1 : r_bar;
            w_bpx_nxt = (r_bpx == 12'(BAR_W-1)) ? 12'd0 : r_bpx + 12'd1;
        end
        w_pix = (r_pat == 2'd0) ? BARS[w_bar_nxt] :
                (r_pat == 2'd1) ? {w_col_nxt[8:4], w_line_nxt[7:2], 5'd0} :
                (r_pat == 2'd2) ? r_solid :
                {16{w_col_nxt[4] ^ w_line_nxt[3] ^ frame_cnt[0]}};
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= IDLE;
            r_col      <= 12'd0;
            r_line     <= 12'd0;
            r_bar      <= 3'd0;
            r_bpx      <= 12'd0;
            r_pat      <= 2'd0;
            r_solid    <= 16'd0;
            cam_data   <= 8'd0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_line     <= w_line_nxt;
            r_bar      <= w_bar_nxt;
            r_bpx      <= w_bpx_nxt;
            if (w_state_nxt == VSYNC && r_state != VSYNC) begin
                r_pat   <= pattern_sel;
                r_solid <= solid_rgb;
            end
            cam_vsync  <= w_state_nxt == VSYNC;
            cam_href   <= w_href_nxt;
            cam_data   <= w_href_nxt ? (w_col_nxt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'd0;
            frame_done <= w_last_nxt;
            if (w_last_nxt)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: directed frame captures on a reduced 8x2 frame, compared
// against hand-derived timing and a small pixel model.
module tb_cam_pattern_gen;
    localparam int HA = 8, HB = 4, VA = 2;
    localparam int LL = 2*HA + HB;
    localparam int FP = 5*LL;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        PCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'd0;
    logic [7:0]  cam_data;
    logic        cam_vsync, cam_href, frame_done;
    logic [7:0]  frame_cnt;

    int n_vec = 0, n_bad = 0;
    logic       g_vs [FP];
    logic       g_hr [FP];
    logic       g_fd [FP];
    logic [7:0] g_dt [FP];
    logic [7:0] g_fc;

    cam_pattern_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                      .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut (
        .PCLK(PCLK), .HRESETn(HRESETn), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .cam_data(cam_data), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(int pat, logic [15:0] sol, int fc, int y, int c);
        int x = c/2;
        logic [7:0] xv = 8'(x);
        logic [7:0] yv = 8'(y);
        logic [7:0] fv = 8'(fc);
        logic [15:0] p;
        case (pat)
            0:       p = BARS[x/(HA/8)];
            1:       p = {xv[7:3], yv[7:2], 5'd0};
            2:       p = sol;
            default: p = {16{xv[3] ^ yv[3] ^ fv[0]}};
        endcase
        return (c % 2 == 1) ? p[7:0] : p[15:8];
    endfunction

    // One full frame, starting with the edge that enters VSYNC; optional input change at index chg_i.
    task automatic capture(input int chg_i, input logic [1:0] chg_pat, input logic chg_en);
        for (int i = 0; i < FP; i++) begin
            tick();
            g_vs[i] = cam_vsync;
            g_hr[i] = cam_href;
            g_fd[i] = frame_done;
            g_dt[i] = cam_data;
            if (i == chg_i) begin
                pattern_sel = chg_pat;
                solid_rgb   = 16'h1234;
                enable      = chg_en;
            end
        end
        g_fc = frame_cnt;
    endtask

    task automatic check_frame(input int pat, input logic [15:0] sol, input int fc);
        logic [159:0] ev = '0, gv = '0, eh = '0, gh = '0, ef = '0, gf = '0;
        logic [7:0] gz = 8'd0;
        for (int i = 0; i < FP; i++) begin
            ev[i] = i < LL;
            gv[i] = g_vs[i];
            eh[i] = (i >= 2*LL && i < 2*LL + 2*HA) || (i >= 3*LL && i < 3*LL + 2*HA);
            gh[i] = g_hr[i];
            ef[i] = i == FP-1;
            gf[i] = g_fd[i];
            if (i < 2*LL || i >= 4*LL)
                gz |= g_dt[i];
        end
        check("vsync", gv, ev);
        check("href", gh, eh);
        check("frame_done", gf, ef);
        check("data-blank", {152'd0, gz}, 160'd0);
        for (int l = 0; l < VA; l++) begin
            logic [159:0] el = '0, gl = '0;
            for (int c = 0; c < LL; c++) begin
                gl[c*8 +: 8] = g_dt[(2+l)*LL + c];
                el[c*8 +: 8] = (c < 2*HA) ? exp_byte(pat, sol, fc, l, c) : 8'd0;
            end
            check($sformatf("line%0d", l), gl, el);
        end
    endtask

    initial begin
        int nz;
        repeat (3) tick();
        check("reset-out", {cam_data, cam_vsync, cam_href, frame_done, frame_cnt}, 160'd0);
        #2 HRESETn = 1'b1;
        tick();
        check("idle-out", {cam_data, cam_vsync, cam_href, frame_done, frame_cnt}, 160'd0);

        enable = 1'b1;
        pattern_sel = 2'd0;
        capture(-1, 2'd0, 1'b1);
        check_frame(0, 16'd0, 0);
        check("fcnt1", g_fc, 1);

        capture(2*LL + 5, 2'd2, 1'b1);
        check_frame(0, 16'd0, 1);
        capture(-1, 2'd2, 1'b1);
        check_frame(2, 16'h1234, 2);
        check("fcnt3", g_fc, 3);

        capture(LL + 10, 2'd2, 1'b0);
        check_frame(2, 16'h1234, 3);
        check("fcnt4", g_fc, 4);
        nz = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cam_vsync || cam_href || frame_done) nz++;
        end
        check("stay-idle", nz, 0);

        pattern_sel = 2'd3;
        enable = 1'b1;
        for (int k = 5; k <= 257; k++) begin
            capture(-1, 2'd3, 1'b1);
            check_frame(3, 16'd0, k-1);
            check($sformatf("fcnt%0d", k), g_fc, k % 256);
        end

        repeat (2*LL + 5) tick();
        check("pre-reset href", cam_href, 1);
        #2 HRESETn = 1'b0;
        #1 check("async-reset", {cam_data, cam_vsync, cam_href, frame_done, frame_cnt}, 160'd0);
        enable = 1'b0;
        pattern_sel = 2'd0;
        tick();
        #2 HRESETn = 1'b1;
        nz = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cam_data != 0 || cam_vsync || cam_href || frame_done || frame_cnt != 0) nz++;
        end
        check("idle-1000", nz, 0);

        enable = 1'b1;
        capture(-1, 2'd0, 1'b1);
        check_frame(0, 16'd0, 0);
        check("fcnt-after-reset", g_fc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
